// File: rtl/ps2_scancode_receiver_pkg.sv
// ---------------------------------------------------------------------------
// ps2_scancode_receiver_pkg
// Shared constants, FSM state encoding and the frame parity helper for the
// PS/2 receive path (ps2_line_filter + ps2_scancode_receiver).
// ---------------------------------------------------------------------------
package ps2_scancode_receiver_pkg;

    localparam int PS2_DATA_BITS       = 8;
    localparam int PS2_TIMEOUT_DEFAULT = 100000;
    localparam int PS2_FILTER_DEFAULT  = 8;

    // Frame FSM states, 2-bit encoding.
    typedef enum logic [1:0] {
        PS2_ST_IDLE   = 2'd0,
        PS2_ST_DATA   = 2'd1,
        PS2_ST_PARITY = 2'd2,
        PS2_ST_STOP   = 2'd3
    } ps2_state_e;

    // PS/2 uses odd parity: data plus parity bit must contain an odd number of ones.
    function automatic logic ps2_parity_ok(input logic [PS2_DATA_BITS-1:0] i_data,
                                           input logic                     i_par);
        return ^{i_data, i_par};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ---------------------------------------------------------------------------
// ps2_line_filter
// Two-flop synchronizer followed by an agreement filter for the PS/2 clock
// pin. The filtered level changes only after FILTER_LEN consecutive
// synchronized samples disagree with it. A one-cycle strobe marks every
// falling edge of the filtered level.
// Ports:
//   clk     in   system clock
//   reset   in   asynchronous active-high reset (line held at idle level 1)
//   i_pin   in   raw asynchronous pin
//   o_fall  out  one-cycle strobe on filtered falling edge
// ---------------------------------------------------------------------------
module ps2_line_filter
    import ps2_scancode_receiver_pkg::*;
#(
    parameter int FILTER_LEN = PS2_FILTER_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic i_pin,
    output logic o_fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_filt;
    logic          r_filt_d;
    logic [CW-1:0] r_cnt;

    // Two-flop synchronizer for the raw pin, idle high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
        end
    end

    // Agreement filter: r_cnt counts disagreeing samples; any agreeing sample restarts it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_filt   <= 1'b1;
            r_filt_d <= 1'b1;
            r_cnt    <= '0;
        end else begin
            r_filt_d <= r_filt;
            if (r_sync2 == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_filt <= r_sync2;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_fall = r_filt_d & ~r_filt;

endmodule

// File: rtl/ps2_scancode_receiver.sv
// ---------------------------------------------------------------------------
// ps2_scancode_receiver
// Receive-only PS/2 device-to-host deserializer. Frames the 11-bit packet
// (start, 8 data LSB first, odd parity, stop) on falling edges of the
// filtered PS/2 clock, checks it and pushes good bytes to the scancode FIFO.
// Exactly one result pulse is produced per frame, one cycle after the stop
// bit strobe. A stalled frame is abandoned after TIMEOUT_CYCLES.
// Ports:
//   clk           in   system clock
//   reset         in   asynchronous active-high reset
//   ps2_clk       in   raw PS/2 clock pin
//   ps2_dat       in   raw PS/2 data pin
//   fifo_full     in   FIFO full flag, sampled at the stop strobe
//   fifo_push     out  one-cycle push strobe
//   fifo_data     out  [7:0] byte, meaningful while fifo_push=1
//   parity_error  out  one-cycle pulse, frame dropped on parity
//   frame_error   out  one-cycle pulse, bad start/stop or timeout
//   overflow      out  one-cycle pulse, good frame dropped on fifo_full
// ---------------------------------------------------------------------------
module ps2_scancode_receiver
    import ps2_scancode_receiver_pkg::*;
#(
    parameter int FILTER_LEN     = PS2_FILTER_DEFAULT,
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    input  logic       fifo_full,
    output logic       fifo_push,
    output logic [7:0] fifo_data,
    output logic       parity_error,
    output logic       frame_error,
    output logic       overflow
);

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_MAX  = {TW{1'b1}};

    logic          w_strobe;
    logic          r_dat_s1;
    logic          r_dat_s2;

    ps2_state_e    r_state,  w_state_nxt;
    logic [7:0]    r_shift,  w_shift_nxt;
    logic [2:0]    r_bitcnt, w_bitcnt_nxt;
    logic          r_par,    w_par_nxt;
    logic [TW-1:0] r_tmo,    w_tmo_nxt;
    logic [7:0]    r_data,   w_data_nxt;
    logic          r_push,   w_push_nxt;
    logic          r_perr,   w_perr_nxt;
    logic          r_ferr,   w_ferr_nxt;
    logic          r_ovf,    w_ovf_nxt;

    logic          w_tmo_exp;
    logic [TW-1:0] w_tmo_inc;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk    (clk),
        .reset  (reset),
        .i_pin  (ps2_clk),
        .o_fall (w_strobe)
    );

    // Two-flop synchronizer for the data pin; no filter, it is sampled mid-bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_dat_s1 <= ps2_dat;
            r_dat_s2 <= r_dat_s1;
        end
    end

    assign w_tmo_exp = (r_tmo == TMO_LAST);
    assign w_tmo_inc = (r_tmo == TMO_MAX) ? r_tmo : (r_tmo + TW'(1));

    // Next-state, datapath and result-pulse logic. A strobe always wins over timeout expiry.
    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_bitcnt_nxt = r_bitcnt;
        w_par_nxt    = r_par;
        w_tmo_nxt    = r_tmo;
        w_data_nxt   = r_data;
        w_push_nxt   = 1'b0;
        w_perr_nxt   = 1'b0;
        w_ferr_nxt   = 1'b0;
        w_ovf_nxt    = 1'b0;

        case (r_state)
            PS2_ST_IDLE: begin
                w_tmo_nxt = '0;
                if (w_strobe) begin
                    if (!r_dat_s2) begin
                        w_state_nxt  = PS2_ST_DATA;
                        w_bitcnt_nxt = 3'd0;
                        w_shift_nxt  = 8'h00;
                    end else begin
                        w_ferr_nxt = 1'b1;
                    end
                end else begin
                    w_state_nxt = PS2_ST_IDLE;
                end
            end

            PS2_ST_DATA: begin
                if (w_strobe) begin
                    w_shift_nxt = {r_dat_s2, r_shift[7:1]};
                    w_tmo_nxt   = '0;
                    if (r_bitcnt == 3'd7) begin
                        w_state_nxt = PS2_ST_PARITY;
                    end else begin
                        w_bitcnt_nxt = r_bitcnt + 3'd1;
                    end
                end else if (w_tmo_exp) begin
                    w_state_nxt  = PS2_ST_IDLE;
                    w_ferr_nxt   = 1'b1;
                    w_tmo_nxt    = '0;
                    w_shift_nxt  = 8'h00;
                    w_bitcnt_nxt = 3'd0;
                end else begin
                    w_tmo_nxt = w_tmo_inc;
                end
            end

            PS2_ST_PARITY: begin
                if (w_strobe) begin
                    w_par_nxt   = r_dat_s2;
                    w_state_nxt = PS2_ST_STOP;
                    w_tmo_nxt   = '0;
                end else if (w_tmo_exp) begin
                    w_state_nxt  = PS2_ST_IDLE;
                    w_ferr_nxt   = 1'b1;
                    w_tmo_nxt    = '0;
                    w_shift_nxt  = 8'h00;
                    w_bitcnt_nxt = 3'd0;
                end else begin
                    w_tmo_nxt = w_tmo_inc;
                end
            end

            PS2_ST_STOP: begin
                if (w_strobe) begin
                    w_state_nxt  = PS2_ST_IDLE;
                    w_tmo_nxt    = '0;
                    w_bitcnt_nxt = 3'd0;
                    if (!r_dat_s2) begin
                        w_ferr_nxt = 1'b1;
                    end else if (!ps2_parity_ok(r_shift, r_par)) begin
                        w_perr_nxt = 1'b1;
                    end else if (fifo_full) begin
                        w_ovf_nxt = 1'b1;
                    end else begin
                        w_push_nxt = 1'b1;
                        w_data_nxt = r_shift;
                    end
                end else if (w_tmo_exp) begin
                    w_state_nxt  = PS2_ST_IDLE;
                    w_ferr_nxt   = 1'b1;
                    w_tmo_nxt    = '0;
                    w_shift_nxt  = 8'h00;
                    w_bitcnt_nxt = 3'd0;
                end else begin
                    w_tmo_nxt = w_tmo_inc;
                end
            end

            default: begin
                w_state_nxt  = PS2_ST_IDLE;
                w_tmo_nxt    = '0;
                w_shift_nxt  = 8'h00;
                w_bitcnt_nxt = 3'd0;
            end
        endcase
    end

    // State, datapath and registered output pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= PS2_ST_IDLE;
            r_shift  <= 8'h00;
            r_bitcnt <= 3'd0;
            r_par    <= 1'b0;
            r_tmo    <= '0;
            r_data   <= 8'h00;
            r_push   <= 1'b0;
            r_perr   <= 1'b0;
            r_ferr   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_par    <= w_par_nxt;
            r_tmo    <= w_tmo_nxt;
            r_data   <= w_data_nxt;
            r_push   <= w_push_nxt;
            r_perr   <= w_perr_nxt;
            r_ferr   <= w_ferr_nxt;
            r_ovf    <= w_ovf_nxt;
        end
    end

    assign fifo_push    = r_push;
    assign fifo_data    = r_data;
    assign parity_error = r_perr;
    assign frame_error  = r_ferr;
    assign overflow     = r_ovf;

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// ---------------------------------------------------------------------------
// tb_ps2_scancode_receiver
// Drives PS/2 frames onto the pins, queues the expected result of each frame
// from a frame-level model, and lets an independent monitor pop and compare
// every result pulse the DUT produces.
// ---------------------------------------------------------------------------
module tb_ps2_scancode_receiver;

    localparam int FILT = 8;
    localparam int TMO  = 300;
    localparam int HALF = 20;
    localparam int GAP  = 60;
    // raw stop-bit falling edge -> 2 sync + FILT agreement + edge detect + output register
    localparam int LAT  = FILT + 3;

    typedef enum int {EV_PUSH = 0, EV_PERR = 1, EV_FERR = 2, EV_OVF = 3} ev_e;
    typedef struct {
        ev_e        kind;
        logic [7:0] data;
        bit         chk_lat;
    } exp_t;

    exp_t exp_q[$];

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_dat;
    logic       fifo_full;
    logic       fifo_push;
    logic [7:0] fifo_data;
    logic       parity_error;
    logic       frame_error;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t_fall = 0;
    int ev_cnt = 0;
    logic [3:0] prev_w = 4'b0000;

    ps2_scancode_receiver #(
        .FILTER_LEN     (FILT),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ps2_clk      (ps2_clk),
        .ps2_dat      (ps2_dat),
        .fifo_full    (fifo_full),
        .fifo_push    (fifo_push),
        .fifo_data    (fifo_data),
        .parity_error (parity_error),
        .frame_error  (frame_error),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Frame-level reference: result of a received frame from its fields.
    function automatic ev_e model(input logic [7:0] d, input logic par, input logic stop,
                                  input logic full);
        int ones;
        ones = $countones(d) + int'(par);
        if (stop == 1'b0)      return EV_FERR;
        else if (ones % 2 == 0) return EV_PERR;
        else if (full)         return EV_OVF;
        else                   return EV_PUSH;
    endfunction

    // Monitor: pops one expectation per result pulse.
    always @(negedge clk) begin : monitor
        logic [3:0] w;
        exp_t       e;
        if (reset !== 1'b1) begin
            w = {fifo_push, parity_error, frame_error, overflow};
            if (w != 4'b0000) begin
                ev_cnt++;
                check("pulse_width", int'(prev_w & w), 0);
                check("one_hot", $countones(w), 1);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", int'(w), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("kind", (fifo_push ? 0 : parity_error ? 1 : frame_error ? 2 : 3),
                          int'(e.kind));
                    if (e.kind == EV_PUSH && fifo_push) check("fifo_data", int'(fifo_data), int'(e.data));
                    if (e.chk_lat) check("latency", cyc - t_fall, LAT);
                end
            end
            prev_w = w;
        end else begin
            prev_w = 4'b0000;
        end
    end

    task automatic clock_bit(input logic b);
        ps2_dat = b;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b0;
        t_fall = cyc;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b1;
    endtask

    task automatic send_expect(input logic [7:0] d, input logic bad_par, input logic stop,
                               input logic full);
        logic par;
        exp_t e;
        par = (~^d) ^ bad_par;
        e.kind = model(d, par, stop, full);
        e.data = d;
        e.chk_lat = 1'b1;
        exp_q.push_back(e);
        fifo_full = full;
        clock_bit(1'b0);
        for (int i = 0; i < 8; i++) clock_bit(d[i]);
        clock_bit(par);
        clock_bit(stop);
        ps2_dat = 1'b1;
        fifo_full = 1'b0;
        repeat (GAP) @(posedge clk);
        #1;
    endtask

    task automatic check_outs_zero(input string name);
        @(negedge clk);
        check(name, int'({fifo_push, parity_error, frame_error, overflow}), 0);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        exp_t e;
        int   ev0;
        reset = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1; fifo_full = 1'b0;
        repeat (5) @(posedge clk);
        check_outs_zero("reset_outputs");
        @(posedge clk); #1 reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        send_expect(8'h1C, 1'b0, 1'b1, 1'b0);
        send_expect(8'hF0, 1'b0, 1'b1, 1'b0);
        send_expect(8'h1C, 1'b0, 1'b1, 1'b0);
        send_expect(8'h1C, 1'b1, 1'b1, 1'b0);
        send_expect(8'h29, 1'b0, 1'b1, 1'b0);
        send_expect(8'h1C, 1'b0, 1'b1, 1'b1);
        send_expect(8'h32, 1'b0, 1'b1, 1'b0);
        send_expect(8'hA5, 1'b0, 1'b0, 1'b0);

        // timeout: start + 3 data bits, then a silent clock line
        e.kind = EV_FERR; e.data = 8'h00; e.chk_lat = 1'b0;
        exp_q.push_back(e);
        clock_bit(1'b0);
        for (int i = 0; i < 3; i++) clock_bit(1'($urandom_range(0, 1)));
        ps2_dat = 1'b1;
        repeat (TMO + 60) @(posedge clk);
        #1;
        check("timeout_drained", exp_q.size(), 0);
        send_expect(8'h1C, 1'b0, 1'b1, 1'b0);

        // sub-threshold glitches on an idle line
        ev0 = ev_cnt;
        for (int g = 0; g < 10; g++) begin
            @(posedge clk); #1 ps2_clk = 1'b0;
            repeat (FILT - 1) @(posedge clk);
            #1 ps2_clk = 1'b1;
            repeat (20) @(posedge clk);
        end
        repeat (40) @(posedge clk);
        #1;
        check("glitch_no_event", ev_cnt - ev0, 0);

        // reset in the middle of a frame
        clock_bit(1'b0);
        for (int i = 0; i < 4; i++) clock_bit(1'b1);
        ps2_dat = 1'b1;
        @(posedge clk); #1 reset = 1'b1;
        check_outs_zero("midframe_reset_outputs");
        check_outs_zero("midframe_reset_outputs2");
        @(posedge clk); #1 reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        send_expect(8'h5A, 1'b0, 1'b1, 1'b0);

        for (int r = 0; r < 16; r++) begin
            send_expect(8'($urandom), 1'($urandom_range(0, 4) == 0),
                        1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 3) == 0));
        end

        repeat (100) @(posedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
